blockmem_write_arbiter: RTL

BLOCKMEM_WRITE_ARBITER -- requirements
Module: blockmem_write_arbiter

---
 rtl/blockmem_pkg.sv | 15 +
 rtl/req_hold_reg.sv | 48 ++++
 rtl/blockmem_write_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/blockmem_pkg.sv
// Shared definitions for the block-memory write arbiter: requester encoding
// and the loader block size derived from the mesh/tile geometry.
package blockmem_pkg;

  typedef enum logic [0:0] {
    REQ_ARRAY  = 1'b0,
    REQ_LOADER = 1'b1
  } req_e;

  // A loader block covers a full mesh of tiles: (mesh*tile)^2 words.
  function automatic int block_size(input int meshUnits, input int tileUnits);
    return meshUnits * meshUnits * tileUnits * tileUnits;
  endfunction

endpackage

// File: rtl/req_hold_reg.sv
// Single-entry valid/ready holding register. The entry stays full until the
// arbiter grants it; a grant frees the slot for a capture on the same edge.
module req_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             grant_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  // Ready is held low during reset so nothing is captured into a cleared slot.
  assign in_ready_o = ~reset & (~full_q | grant_i);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/blockmem_write_arbiter.sv
// Arbitrates array tile writes and loader block writes onto one block memory.
// Optional macro BLOCKMEM_ARB_PERF_EN adds the conflict_cycles contention counter.
module blockmem_write_arbiter
  import blockmem_pkg::*;
#(
  parameter int ADDRSIZE  = 256,
  parameter int BITWIDTH  = 8,
  parameter int MESHUNITS = 2,
  parameter int TILEUNITS = 2,
  localparam int BLOCK_SIZE = block_size(MESHUNITS, TILEUNITS)
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              arr_req_valid,
  output logic                                              arr_req_ready,
  input  logic [MESHUNITS-1:0][BITWIDTH-1:0]                arr_req_addrs,
  input  logic [MESHUNITS-1:0]                              arr_req_mask,
  input  logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] arr_req_data,
  input  logic                                              ld_req_valid,
  output logic                                              ld_req_ready,
  input  logic [BITWIDTH-1:0]                               ld_req_addr,
  input  logic [BLOCK_SIZE-1:0][BITWIDTH-1:0]               ld_req_data,
  output logic [MESHUNITS-1:0][BITWIDTH-1:0]                C_tile_write_addrs,
  output logic [MESHUNITS-1:0]                              C_write_valid,
  output logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] C,
  output logic [BITWIDTH-1:0]                               loader_write_addr,
  output logic                                              loader_write_valid,
  output logic [BLOCK_SIZE-1:0][BITWIDTH-1:0]               loader_write_data,
  output logic                                              busy,
  output logic [31:0]                                       conflict_cycles
);

  localparam int ADDRS_W = MESHUNITS * BITWIDTH;
  localparam int CDATA_W = MESHUNITS * TILEUNITS * BITWIDTH;
  localparam int ARR_W   = ADDRS_W + MESHUNITS + CDATA_W;
  localparam int LD_W    = BITWIDTH + BLOCK_SIZE * BITWIDTH;

  if (ADDRSIZE < BLOCK_SIZE) begin : g_depth_check
    $error("blockmem_write_arbiter: ADDRSIZE smaller than one loader block");
  end

  logic [ARR_W-1:0] arrIn, arrHeld;
  logic [LD_W-1:0]  ldIn, ldHeld;
  logic             arrFull, ldFull;
  logic             grantArr, grantLd;

  logic [MESHUNITS-1:0][BITWIDTH-1:0]                heldAddrs;
  logic [MESHUNITS-1:0]                              heldMask;
  logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] heldCData;
  logic [BITWIDTH-1:0]                               heldLdAddr;
  logic [BLOCK_SIZE-1:0][BITWIDTH-1:0]               heldLdData;

  assign arrIn = {arr_req_addrs, arr_req_mask, arr_req_data};
  assign ldIn  = {ld_req_addr, ld_req_data};
  assign {heldAddrs, heldMask, heldCData} = arrHeld;
  assign {heldLdAddr, heldLdData}         = ldHeld;

  req_hold_reg #(.WIDTH(ARR_W)) u_arr_hold (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (arr_req_valid),
    .in_ready_o (arr_req_ready),
    .in_data_i  (arrIn),
    .grant_i    (grantArr),
    .full_o     (arrFull),
    .data_o     (arrHeld)
  );

  req_hold_reg #(.WIDTH(LD_W)) u_ld_hold (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (ld_req_valid),
    .in_ready_o (ld_req_ready),
    .in_data_i  (ldIn),
    .grant_i    (grantLd),
    .full_o     (ldFull),
    .data_o     (ldHeld)
  );

  req_e prio_q, prio_d;

  logic [MESHUNITS-1:0]                              cValid_q, cValid_d;
  logic [MESHUNITS-1:0][BITWIDTH-1:0]                cAddrs_q, cAddrs_d;
  logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] cData_q, cData_d;
  logic                                              ldValid_q, ldValid_d;
  logic [BITWIDTH-1:0]                               ldAddr_q, ldAddr_d;
  logic [BLOCK_SIZE-1:0][BITWIDTH-1:0]               ldData_q, ldData_d;

  // A lone full entry always wins; under contention prio decides and then
  // flips to the loser, so each side waits at most one grant.
  always_comb begin
    grantArr = arrFull & (~ldFull | (prio_q == REQ_ARRAY));
    grantLd  = ldFull & ~grantArr;

    prio_d = prio_q;
    if (grantArr) begin
      prio_d = REQ_LOADER;
    end else if (grantLd) begin
      prio_d = REQ_ARRAY;
    end

    cValid_d  = '0;
    cAddrs_d  = cAddrs_q;
    cData_d   = cData_q;
    ldValid_d = 1'b0;
    ldAddr_d  = ldAddr_q;
    ldData_d  = ldData_q;
    if (grantArr) begin
      cValid_d = heldMask;
      cAddrs_d = heldAddrs;
      cData_d  = heldCData;
    end
    if (grantLd) begin
      ldValid_d = 1'b1;
      ldAddr_d  = heldLdAddr;
      ldData_d  = heldLdData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q    <= REQ_ARRAY;
      cValid_q  <= '0;
      cAddrs_q  <= '0;
      cData_q   <= '0;
      ldValid_q <= 1'b0;
      ldAddr_q  <= '0;
      ldData_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      cValid_q  <= cValid_d;
      cAddrs_q  <= cAddrs_d;
      cData_q   <= cData_d;
      ldValid_q <= ldValid_d;
      ldAddr_q  <= ldAddr_d;
      ldData_q  <= ldData_d;
    end
  end

  assign C_tile_write_addrs = cAddrs_q;
  assign C_write_valid      = cValid_q;
  assign C                  = cData_q;
  assign loader_write_addr  = ldAddr_q;
  assign loader_write_valid = ldValid_q;
  assign loader_write_data  = ldData_q;
  assign busy               = arrFull | ldFull | (|cValid_q) | ldValid_q;

`ifdef BLOCKMEM_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;

  // Counts cycles where both requesters are waiting; sticks at all-ones.
  always_comb begin
    conflict_d = conflict_q;
    if (arrFull && ldFull && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cycles = conflict_q;
`else
  assign conflict_cycles = 32'd0;
`endif

endmodule
